// File: rtl/taillight_pkg.sv
// Shared types and default parameter values for the tail-light switch
// conditioning block.
package taillight_pkg;

   // Hazard latch: toggled by each debounced press of the hazard button.
   typedef enum logic {
      HAZ_OFF = 1'b0,
      HAZ_ON  = 1'b1
   } haz_state_t;

   // Per-side turn indicator state, used when auto-cancel is built in.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACTIVE    = 2'd1,
      CANCELLED = 2'd2
   } turn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 16;
   localparam int unsigned DEF_DIM_PERIOD        = 8;
   localparam int unsigned DEF_DIM_DUTY          = 2;
   localparam int unsigned DEF_AUTOCANCEL_CYCLES = 1024;

endpackage

// File: rtl/taillight_debounce.sv
// Two-flop synchronizer followed by a counting debouncer. The debounced
// level flips only after the synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module taillight_debounce
   import taillight_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   logic        sync_p0;
   logic        sync_p1;
   logic [15:0] stable_cnt;

   // Synchronize the raw contact, then count disagreement with the held level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0    <= 1'b0;
         sync_p1    <= 1'b0;
         level      <= 1'b0;
         stable_cnt <= 16'd0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         if (sync_p1 == level) begin
            stable_cnt <= 16'd0;
         end else if ((32'(stable_cnt) + 32'd1) == DEBOUNCE_CYCLES) begin
            level      <= ~level;
            stable_cnt <= 16'd0;
         end else begin
            stable_cnt <= stable_cnt + 16'd1;
         end
      end
   end

endmodule

// File: rtl/taillight_switch_ctrl.sv
// Tail-light switch conditioning: debounces the turn stalk, hazard button,
// brake and run-light switches, resolves left/right conflicts, latches the
// hazard state and generates the run-light dimmer PWM.
// Optional feature: define TAILLIGHT_AUTOCANCEL_EN to add per-side turn
// auto-cancel after AUTOCANCEL_CYCLES cycles of continuous signalling.
module taillight_switch_ctrl
   import taillight_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned DIM_PERIOD        = DEF_DIM_PERIOD,
   parameter int unsigned DIM_DUTY          = DEF_DIM_DUTY,
   parameter int unsigned AUTOCANCEL_CYCLES = DEF_AUTOCANCEL_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic left_sw_i,
   input  logic right_sw_i,
   input  logic hazard_btn_i,
   input  logic brake_sw_i,
   input  logic runlights_sw_i,
   output logic left_o,
   output logic right_o,
   output logic hazard_o,
   output logic brake_o,
   output logic runlights_o,
   output logic clk_dimmer_o
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be within 1..65535");
   end
   if (DIM_PERIOD < 2 || DIM_PERIOD > 255) begin : g_bad_dim_period
      $error("DIM_PERIOD must be within 2..255");
   end
   if (AUTOCANCEL_CYCLES < 1) begin : g_bad_autocancel
      $error("AUTOCANCEL_CYCLES must be at least 1");
   end

   logic deb_left;
   logic deb_right;
   logic deb_haz;
   logic deb_brake;
   logic deb_run;
   logic conflict;

   taillight_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
      .clk(clk), .rst(rst), .raw(left_sw_i), .level(deb_left)
   );
   taillight_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
      .clk(clk), .rst(rst), .raw(right_sw_i), .level(deb_right)
   );
   taillight_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_haz (
      .clk(clk), .rst(rst), .raw(hazard_btn_i), .level(deb_haz)
   );
   taillight_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_brake (
      .clk(clk), .rst(rst), .raw(brake_sw_i), .level(deb_brake)
   );
   taillight_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_run (
      .clk(clk), .rst(rst), .raw(runlights_sw_i), .level(deb_run)
   );

   // Both stalk contacts closed is physically impossible; blank both sides.
   assign conflict = deb_left & deb_right;

   haz_state_t haz_state;
   logic       haz_prev;

   // Hazard latch: one toggle per rising edge of the debounced button.
   always_ff @(posedge clk) begin
      if (rst) begin
         haz_state <= HAZ_OFF;
         haz_prev  <= 1'b0;
         hazard_o  <= 1'b0;
      end else begin
         haz_prev <= deb_haz;
         if (deb_haz && !haz_prev) begin
            case (haz_state)
               HAZ_OFF: begin
                  haz_state <= HAZ_ON;
                  hazard_o  <= 1'b1;
               end
               default: begin
                  haz_state <= HAZ_OFF;
                  hazard_o  <= 1'b0;
               end
            endcase
         end
      end
   end

   logic [7:0] dim_cnt;

   // Brake/run-light pass-through and free-running dimmer PWM.
   always_ff @(posedge clk) begin
      if (rst) begin
         dim_cnt      <= 8'd0;
         brake_o      <= 1'b0;
         runlights_o  <= 1'b0;
         clk_dimmer_o <= 1'b0;
      end else begin
         brake_o      <= deb_brake;
         runlights_o  <= deb_run;
         clk_dimmer_o <= deb_run && (32'(dim_cnt) < DIM_DUTY);
         if (32'(dim_cnt) == DIM_PERIOD - 1) begin
            dim_cnt <= 8'd0;
         end else begin
            dim_cnt <= dim_cnt + 8'd1;
         end
      end
   end

`ifdef TAILLIGHT_AUTOCANCEL_EN
   localparam int unsigned TW = (AUTOCANCEL_CYCLES < 2) ? 1 : $clog2(AUTOCANCEL_CYCLES);

   turn_state_t   turn_st  [2];
   logic [TW-1:0] turn_tmr [2];
   logic [1:0]    side_deb;
   logic [1:0]    turn_q;

   assign side_deb = {deb_right, deb_left};
   assign left_o   = turn_q[0];
   assign right_o  = turn_q[1];

   // Per-side turn FSM: signal while held, cancel after the timeout,
   // re-arm only once the stalk returns to centre.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (rst) begin
            turn_st[s]  <= IDLE;
            turn_tmr[s] <= '0;
            turn_q[s]   <= 1'b0;
         end else begin
            case (turn_st[s])
               IDLE: begin
                  if (side_deb[s]) begin
                     turn_st[s]  <= ACTIVE;
                     turn_tmr[s] <= '0;
                     turn_q[s]   <= ~conflict;
                  end else begin
                     turn_q[s] <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (!side_deb[s]) begin
                     turn_st[s] <= IDLE;
                     turn_q[s]  <= 1'b0;
                  end else if ((32'(turn_tmr[s]) + 32'd1) == AUTOCANCEL_CYCLES) begin
                     turn_st[s]  <= CANCELLED;
                     turn_tmr[s] <= '0;
                     turn_q[s]   <= 1'b0;
                  end else begin
                     turn_tmr[s] <= turn_tmr[s] + TW'(1);
                     turn_q[s]   <= ~conflict;
                  end
               end
               default: begin
                  if (!side_deb[s]) begin
                     turn_st[s] <= IDLE;
                  end
                  turn_q[s] <= 1'b0;
               end
            endcase
         end
      end
   end
`else
   // Turn outputs follow the debounced stalk, blanked during a conflict.
   always_ff @(posedge clk) begin
      if (rst) begin
         left_o  <= 1'b0;
         right_o <= 1'b0;
      end else begin
         left_o  <= deb_left & ~conflict;
         right_o <= deb_right & ~conflict;
      end
   end
`endif

endmodule

// File: tb/tb_taillight_switch_ctrl.sv
// Scoreboard bench for taillight_switch_ctrl: directed scenarios followed by
// randomized switch activity, each cycle predicted by a window-based model.
module tb_taillight_switch_ctrl;

   localparam int D    = 4;
   localparam int P    = 8;
   localparam int DUTY = 2;
   localparam int AC   = 20;
   localparam int MAXC = 4096;

   localparam bit [4:0] L   = 5'b00001;
   localparam bit [4:0] R   = 5'b00010;
   localparam bit [4:0] H   = 5'b00100;
   localparam bit [4:0] B   = 5'b01000;
   localparam bit [4:0] RUN = 5'b10000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic left_sw_i = 1'b0, right_sw_i = 1'b0, hazard_btn_i = 1'b0;
   logic brake_sw_i = 1'b0, runlights_sw_i = 1'b0;
   logic left_o, right_o, hazard_o, brake_o, runlights_o, clk_dimmer_o;

   taillight_switch_ctrl #(
      .DEBOUNCE_CYCLES(D), .DIM_PERIOD(P), .DIM_DUTY(DUTY), .AUTOCANCEL_CYCLES(AC)
   ) dut (
      .clk(clk), .rst(rst),
      .left_sw_i(left_sw_i), .right_sw_i(right_sw_i), .hazard_btn_i(hazard_btn_i),
      .brake_sw_i(brake_sw_i), .runlights_sw_i(runlights_sw_i),
      .left_o(left_o), .right_o(right_o), .hazard_o(hazard_o),
      .brake_o(brake_o), .runlights_o(runlights_o), .clk_dimmer_o(clk_dimmer_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      bit l, r, h, b, run, dim;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   started = 1'b0;

   // Model state: raw sample history, debounced level history per signal
   // (0 left, 1 right, 2 hazard, 3 brake, 4 run), latest reset edge.
   bit raw_h [5][MAXC];
   bit lvl_h [5][MAXC];
   int last_rst = 0;
   bit haz_on   = 1'b0;
   int on_since [2] = '{-1, -1};
   int cyc = 0;

   // Value the debouncer observes at edge m: the raw sample two edges
   // earlier, or 0 while the synchronizer is still refilling after reset.
   function automatic bit seen(input int i, input int m);
      if (m - 2 > last_rst) return raw_h[i][m-2];
      return 1'b0;
   endfunction

   task automatic model_edge(input bit r, input bit [4:0] v);
      exp_t e;
      bit   pv [5];
      bit   flip;
      e.n = cyc;
      for (int i = 0; i < 5; i++) raw_h[i][cyc] = v[i];
      if (r) begin
         last_rst = cyc;
         for (int i = 0; i < 5; i++) lvl_h[i][cyc] = 1'b0;
         haz_on = 1'b0;
         on_since[0] = -1;
         on_since[1] = -1;
         e.l = 0; e.r = 0; e.h = 0; e.b = 0; e.run = 0; e.dim = 0;
      end else begin
         for (int i = 0; i < 5; i++) pv[i] = lvl_h[i][cyc-1];
         if (pv[2] && (cyc - 1 > last_rst) && !lvl_h[2][cyc-2]) haz_on = !haz_on;
`ifdef TAILLIGHT_AUTOCANCEL_EN
         for (int s = 0; s < 2; s++) begin
            if (!pv[s]) on_since[s] = -1;
            else if (on_since[s] < 0) on_since[s] = cyc;
         end
         e.l = (on_since[0] >= 0) && (cyc - on_since[0] < AC) && !(pv[0] && pv[1]);
         e.r = (on_since[1] >= 0) && (cyc - on_since[1] < AC) && !(pv[0] && pv[1]);
`else
         e.l = pv[0] && !pv[1];
         e.r = pv[1] && !pv[0];
`endif
         e.h   = haz_on;
         e.b   = pv[3];
         e.run = pv[4];
         e.dim = pv[4] && (((cyc - 1 - last_rst) % P) < DUTY);
         // A level flips once the last D observed samples all disagree with it.
         for (int i = 0; i < 5; i++) begin
            flip = 1'b1;
            for (int k = 0; k < D; k++) begin
               if ((cyc - k <= last_rst) || (seen(i, cyc - k) == pv[i])) flip = 1'b0;
            end
            lvl_h[i][cyc] = flip ? !pv[i] : pv[i];
         end
      end
      sb.push_back(e);
      cyc++;
   endtask

   task automatic step(input bit r, input bit [4:0] v);
      @(negedge clk);
      rst            = r;
      left_sw_i      = v[0];
      right_sw_i     = v[1];
      hazard_btn_i   = v[2];
      brake_sw_i     = v[3];
      runlights_sw_i = v[4];
      if (cyc < MAXC) model_edge(r, v);
      started = 1'b1;
   endtask

   task automatic hold(input bit [4:0] v, input int k);
      repeat (k) step(1'b0, v);
   endtask

   task automatic chk(input string name, input logic act, input bit exp, input int n);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s edge %0d: got %b expected %b", name, n, act, exp);
      end
   endtask

   // Monitor: every clock edge after stimulus starts presents one output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (started) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard_empty at time %0t: got 0 entries expected 1", $time);
            end else begin
               e = sb.pop_front();
               chk("left_o",       left_o,       e.l,   e.n);
               chk("right_o",      right_o,      e.r,   e.n);
               chk("hazard_o",     hazard_o,     e.h,   e.n);
               chk("brake_o",      brake_o,      e.b,   e.n);
               chk("runlights_o",  runlights_o,  e.run, e.n);
               chk("clk_dimmer_o", clk_dimmer_o, e.dim, e.n);
            end
         end
      end
   end

   // Stimulus: directed scenarios, then randomized switch activity.
   initial begin
      bit [4:0] cur;
      int       len [5];
      cur = '0;
      for (int i = 0; i < 5; i++) len[i] = 0;

      repeat (3) step(1'b1, 5'b0);
      hold(5'b0, 7);
      // Left held from edge 10 with a 3-cycle right glitch.
      hold(L, 3); hold(L | R, 3); hold(L, 14); hold(5'b0, 10);
      // Two hazard presses.
      hold(H, 10); hold(5'b0, 10); hold(H, 10); hold(5'b0, 10);
      // Stalk conflict, then right released.
      hold(L | R, 12); hold(L, 10); hold(5'b0, 10);
      // Run lights on and off.
      hold(RUN, 30); hold(5'b0, 20);
      // Long left hold, release and re-raise.
      hold(L, 40); hold(5'b0, 10); hold(L, 15); hold(5'b0, 10);
      // Hazard on, then reset in the middle of a brake debounce.
      hold(H, 10); hold(5'b0, 5);
      hold(B, 3); step(1'b1, B); hold(B, 12); hold(5'b0, 10);

      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < 5; i++) begin
            if (len[i] == 0) begin
               cur[i] = ~cur[i];
               len[i] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, D - 1))
                                                   : int'($urandom_range(D + 1, 40));
            end
            len[i]--;
         end
         step($urandom_range(0, 499) == 0, cur);
      end

      @(posedge clk);
      #3;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
